// File: rtl/knn_vote_pkg.sv
// Shared constants and FSM encoding for the KNN majority-vote classifier.
package knn_vote_pkg;

    localparam int KNN_LABEL       = 8;
    localparam int KNN_N_NEIGHBOUR = 10;
    localparam int KNN_N_CLASS     = 16;
    localparam int KNN_VOTE_W      = $clog2(KNN_N_NEIGHBOUR + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_SCAN  = 2'd2,
        ST_DONE  = 2'd3
    } knn_state_e;

endpackage

// File: rtl/knn_vote_hist.sv
// Per-class vote histogram: one increment port, one combinational read port.
module knn_vote_hist
    import knn_vote_pkg::*;
#(
    parameter int N_CLASS = KNN_N_CLASS,
    parameter int VW      = KNN_VOTE_W,
    parameter int CW      = (N_CLASS > 1) ? $clog2(N_CLASS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          inc_en,
    input  logic [CW-1:0] inc_idx,
    input  logic [CW-1:0] rd_idx,
    output logic [VW-1:0] rd_data
);

    logic [VW-1:0] hist_q [N_CLASS];
    logic [VW-1:0] hist_d [N_CLASS];

    // Next-state of the counters: clear wins over increment.
    always_comb begin
        for (int i = 0; i < N_CLASS; i++) begin
            hist_d[i] = hist_q[i];
        end
        if (clear) begin
            for (int i = 0; i < N_CLASS; i++) begin
                hist_d[i] = '0;
            end
        end else if (inc_en) begin
            hist_d[inc_idx] = hist_q[inc_idx] + VW'(1);
        end
    end

    // Counter registers, zeroed by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_CLASS; i++) begin
                hist_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_CLASS; i++) begin
                hist_q[i] <= hist_d[i];
            end
        end
    end

    assign rd_data = hist_q[rd_idx];

endmodule

// File: rtl/knn_vote.sv
// Majority-vote classifier: counts K neighbour labels, then scans for the
// most frequent class (lowest index wins ties).
//
// state | meaning
// IDLE  | waiting for start; last result held on outputs
// COUNT | one neighbour slot per cycle into the histogram
// SCAN  | one class per cycle, strict-greater argmax
// DONE  | publish result, pulse done, back to IDLE
module knn_vote
    import knn_vote_pkg::*;
#(
    parameter int LABEL       = KNN_LABEL,
    parameter int N_Neighbour = KNN_N_NEIGHBOUR,
    parameter int N_CLASS     = KNN_N_CLASS
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic [N_Neighbour*LABEL-1:0]       neighbour_info,
    input  logic [$clog2(N_Neighbour+1)-1:0]   n_valid,
    output logic                               busy,
    output logic                               done,
    output logic [LABEL-1:0]                   class_out,
    output logic [$clog2(N_Neighbour+1)-1:0]   votes,
    output logic                               err
);

    localparam int VW = $clog2(N_Neighbour + 1);
    localparam int CW = (N_CLASS > 1) ? $clog2(N_CLASS) : 1;

    knn_state_e                   state_q, state_d;
    logic [VW-1:0]                idx_q, idx_d;
    logic [CW-1:0]                cls_q, cls_d;
    logic [VW-1:0]                nv_q, nv_d;
    logic [N_Neighbour*LABEL-1:0] info_q, info_d;
    logic [VW-1:0]                best_cnt_q, best_cnt_d;
    logic [LABEL-1:0]             best_cls_q, best_cls_d;
    logic                         err_int_q, err_int_d;
    logic                         busy_q, busy_d;
    logic                         done_q, done_d;
    logic [LABEL-1:0]             class_out_q, class_out_d;
    logic [VW-1:0]                votes_q, votes_d;
    logic                         err_q, err_d;

    logic [LABEL-1:0] slot [N_Neighbour];
    logic [LABEL-1:0] cur_label;
    logic             label_legal;
    logic [VW-1:0]    nv_clamp;
    logic             hist_clear;
    logic             hist_inc;
    logic [VW-1:0]    hist_rd;

    // Unpack the latched label vector so the current slot can be indexed.
    always_comb begin
        for (int i = 0; i < N_Neighbour; i++) begin
            slot[i] = info_q[i*LABEL +: LABEL];
        end
    end

    assign cur_label   = slot[idx_q];
    assign label_legal = (32'(cur_label) < N_CLASS);
    assign nv_clamp    = (32'(n_valid) > N_Neighbour) ? VW'(N_Neighbour) : n_valid;

    knn_vote_hist #(
        .N_CLASS (N_CLASS),
        .VW      (VW),
        .CW      (CW)
    ) u_hist (
        .clk     (clk),
        .rst     (rst),
        .clear   (hist_clear),
        .inc_en  (hist_inc),
        .inc_idx (cur_label[CW-1:0]),
        .rd_idx  (cls_q),
        .rd_data (hist_rd)
    );

    // Sequencing, counting and argmax next-state logic.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cls_d       = cls_q;
        nv_d        = nv_q;
        info_d      = info_q;
        best_cnt_d  = best_cnt_q;
        best_cls_d  = best_cls_q;
        err_int_d   = err_int_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        class_out_d = class_out_q;
        votes_d     = votes_q;
        err_d       = err_q;
        hist_clear  = 1'b0;
        hist_inc    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    info_d     = neighbour_info;
                    nv_d       = nv_clamp;
                    idx_d      = '0;
                    cls_d      = '0;
                    best_cnt_d = '0;
                    best_cls_d = '0;
                    err_int_d  = 1'b0;
                    hist_clear = 1'b1;
                    busy_d     = 1'b1;
                    state_d    = (nv_clamp == '0) ? ST_SCAN : ST_COUNT;
                end
            end
            ST_COUNT: begin
                if (label_legal) begin
                    hist_inc = 1'b1;
                end else begin
                    err_int_d = 1'b1;
                end
                if (idx_q == nv_q - VW'(1)) begin
                    state_d = ST_SCAN;
                end else begin
                    idx_d = idx_q + VW'(1);
                end
            end
            ST_SCAN: begin
                if (hist_rd > best_cnt_q) begin
                    best_cnt_d = hist_rd;
                    best_cls_d = LABEL'(cls_q);
                end
                if (cls_q == CW'(N_CLASS - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    cls_d = cls_q + CW'(1);
                end
            end
            ST_DONE: begin
                class_out_d = best_cls_q;
                votes_d     = best_cnt_q;
                err_d       = err_int_q;
                done_d      = 1'b1;
                busy_d      = 1'b0;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // All control and output registers; reset discards any partial result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            cls_q       <= '0;
            nv_q        <= '0;
            info_q      <= '0;
            best_cnt_q  <= '0;
            best_cls_q  <= '0;
            err_int_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            class_out_q <= '0;
            votes_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cls_q       <= cls_d;
            nv_q        <= nv_d;
            info_q      <= info_d;
            best_cnt_q  <= best_cnt_d;
            best_cls_q  <= best_cls_d;
            err_int_q   <= err_int_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            class_out_q <= class_out_d;
            votes_q     <= votes_d;
            err_q       <= err_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign class_out = class_out_q;
    assign votes     = votes_q;
    assign err       = err_q;

endmodule

// File: tb/tb_knn_vote.sv
// Directed bench for knn_vote: hand-computed votes, classes and latencies.
module tb_knn_vote;

    localparam int LABEL = 8;
    localparam int NN    = 10;
    localparam int VW    = $clog2(NN + 1);

    typedef logic [LABEL-1:0] lbl_arr_t [NN];

    logic                clk;
    logic                rst;
    logic                start;
    logic [NN*LABEL-1:0] neighbour_info;
    logic [VW-1:0]       n_valid;
    logic                busy;
    logic                done;
    logic [LABEL-1:0]    class_out;
    logic [VW-1:0]       votes;
    logic                err;

    int n_cmp;
    int n_mis;

    knn_vote #(
        .LABEL       (LABEL),
        .N_Neighbour (NN),
        .N_CLASS     (16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .neighbour_info (neighbour_info),
        .n_valid        (n_valid),
        .busy           (busy),
        .done           (done),
        .class_out      (class_out),
        .votes          (votes),
        .err            (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [NN*LABEL-1:0] pack(input lbl_arr_t a);
        logic [NN*LABEL-1:0] v;
        v = '0;
        for (int i = 0; i < NN; i++) begin
            v[i*LABEL +: LABEL] = a[i];
        end
        return v;
    endfunction

    // Runs one classification starting at a negedge; returns at the negedge
    // of the cycle after done, so a chained call starts right after done.
    task automatic run_job(input string tag, input lbl_arr_t lbl, input int nv,
                           input int exp_cls, input int exp_votes, input int exp_err,
                           input int exp_lat, input bit pulse_mid);
        int  lat;
        bit  seen;
        neighbour_info = pack(lbl);
        n_valid        = VW'(nv);
        start          = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start          = 1'b0;
        neighbour_info = {NN{8'hAA}};
        n_valid        = '0;
        check({tag, ".busy_rise"}, int'(busy), 1);
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 60) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            start = (pulse_mid && lat == 2) ? 1'b1 : 1'b0;
            if (done) seen = 1'b1;
        end
        start = 1'b0;
        check({tag, ".latency"}, lat, exp_lat);
        if (seen) begin
            check({tag, ".busy_at_done"}, int'(busy), 0);
            check({tag, ".class"}, int'(class_out), exp_cls);
            check({tag, ".votes"}, int'(votes), exp_votes);
            check({tag, ".err"}, int'(err), exp_err);
            @(posedge clk);
            @(negedge clk);
            check({tag, ".done_one_cycle"}, int'(done), 0);
            check({tag, ".hold_class"}, int'(class_out), exp_cls);
        end
    endtask

    initial begin
        n_cmp          = 0;
        n_mis          = 0;
        rst            = 1'b0;
        start          = 1'b0;
        neighbour_info = '0;
        n_valid        = '0;
        repeat (3) @(negedge clk);
        check("rst.busy", int'(busy), 0);
        check("rst.done", int'(done), 0);
        check("rst.class", int'(class_out), 0);
        check("rst.votes", int'(votes), 0);
        check("rst.err", int'(err), 0);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("idle.no_done", int'(done), 0);
        end

        run_job("majority", '{3,3,7,3,1,7,3,2,3,0}, 10, 3, 5, 0, 27, 1'b0);
        run_job("tie_partial", '{5,2,5,2,9,9,9,9,9,9}, 4, 2, 2, 0, 21, 1'b0);
        run_job("illegal", '{20,1,1,4,4,4,4,4,4,4}, 3, 1, 2, 1, 20, 1'b0);
        run_job("zero_fill", '{5,5,5,5,5,5,5,5,5,5}, 0, 0, 0, 0, 17, 1'b0);
        run_job("clamp", '{6,6,6,6,6,6,6,6,6,6}, 15, 6, 10, 0, 27, 1'b0);
        run_job("start_in_count", '{3,3,7,3,1,7,3,2,3,0}, 10, 3, 5, 0, 27, 1'b1);

        // Reset in the middle of SCAN: slots done after 10 edges, scan runs 16.
        neighbour_info = pack('{9,9,9,1,1,1,1,1,1,1});
        n_valid        = VW'(10);
        start          = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        rst = 1'b0;
        #1;
        check("midscan_rst.busy", int'(busy), 0);
        check("midscan_rst.done", int'(done), 0);
        check("midscan_rst.class", int'(class_out), 0);
        check("midscan_rst.votes", int'(votes), 0);
        check("midscan_rst.err", int'(err), 0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("post_rst.no_done", int'(done), 0);
        end
        run_job("fresh", '{9,9,9,1,1,1,1,1,12,12}, 8, 1, 5, 0, 25, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/knn_vote.md
# knn_vote

Majority-vote classifier downstream of the KNN core. It takes the flattened label vector of the K nearest neighbours, which the core produces nearest-first, and builds a per-class histogram one neighbour per cycle. It then scans the histogram for the winning class and presents the result as a registered output that software reads through the KNN register file. It exists so the CPU no longer has to read K labels and count them in firmware.

## Interface
- `LABEL`, 8: width of one label.
- `N_Neighbour`, 10: number of neighbour slots (K).
- `N_CLASS`, 16: number of classes; legal labels are 0..N_CLASS-1.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low (asserted when 0).
- `start`  in  1  one-cycle request to classify; sampled only in IDLE.
- `neighbour_info`  in  N_Neighbour*LABEL  labels, slot i at bits [(i+1)*LABEL-1 : i*LABEL], slot 0 nearest.
- `n_valid`  in  $clog2(N_Neighbour+1)  number of populated slots, counted from slot 0.
- `busy`  out  1  high from the cycle after an accepted start until done.
- `done`  out  1  one-cycle pulse when the result is valid.
- `class_out`  out  LABEL  winning class.
- `votes`  out  $clog2(N_Neighbour+1)  vote count of the winning class.
- `err`  out  1  at least one counted label was >= N_CLASS.

## Operation
- FSM states are IDLE, COUNT, SCAN and DONE.
- IDLE + start=1:
  - Latch neighbour_info and min(n_valid, N_Neighbour).
  - Clear every histogram counter, the index counter, best_cnt, best_cls and err_int.
  - Go to COUNT, or to SCAN when the clamped n_valid is 0.
- COUNT, one slot per cycle, idx = 0..nv-1:
  - If label < N_CLASS, increment hist[label].
  - Otherwise set err_int and leave the histogram unchanged.
  - After slot nv-1, go to SCAN.
- SCAN, one class per cycle, c = 0..N_CLASS-1:
  - If hist[c] > best_cnt, load best_cnt=hist[c] and best_cls=c.
  - Comparison is strict, so on a tie the lowest class index wins.
  - After c = N_CLASS-1, go to DONE.
- DONE:
  - class_out <= best_cls, votes <= best_cnt, err <= err_int.
  - done=1 for exactly this cycle, then return to IDLE.
- Histogram counters are $clog2(N_Neighbour+1) bits wide and cannot overflow, because nv <= N_Neighbour.
- start while busy is ignored; it is not queued.
- class_out, votes and err hold their values until the next DONE.
- Reset asserted mid-operation forces IDLE immediately. All outputs and counters go to 0 and any partial result is discarded.

## Timing
- Reset values: busy=0, done=0, class_out=0, votes=0, err=0, FSM=IDLE.
- start is sampled at edge t and busy rises after t.
- COUNT occupies nv cycles and SCAN occupies N_CLASS cycles.
- done is high in cycle t+nv+N_CLASS+1, i.e. latency start→done = nv + N_CLASS + 1 cycles. With the defaults that is at most 27.
- busy falls in the same cycle that done rises, so busy and done are never high together.
- start may be reasserted in the cycle after done, which is IDLE; it is accepted then.
- neighbour_info may change freely after the start cycle because it was latched.
- The edge case nv=0 takes N_CLASS+1 cycles and yields class_out=0, votes=0.

## Structure
- Add to the shared header iob_knn.vh:
  - `KNN_N_CLASS`
  - the FSM state encodings, 2 bits: IDLE=0, COUNT=1, SCAN=2, DONE=3
  - `KNN_VOTE_W` = $clog2(N_Neighbour+1)
- Sub-module knn_vote_hist holds the N_CLASS counters.
  - Ports: clear, inc_en, inc_idx, rd_idx, rd_data.
  - The top keeps the FSM, the index counters and the argmax registers.
- Expected size is about 200 RTL lines in total.

## Test plan
- Reset: hold rst=0 for 3 cycles, then release. All outputs must be 0, busy=0, and no done pulse before any start.
- Clear majority: N=10, nv=10, labels {3,3,7,3,1,7,3,2,3,0}, start. Expect done at latency 27 with class_out=3, votes=5, err=0.
- Tie and partial fill: nv=4, labels {5,2,5,2, six slots holding 9}. Expect class_out=2, votes=2, latency 21, and slots 4..9 not counted.
- Illegal label, zero fill and clamp:
  - Labels {20,1,1,...}, nv=3: expect err=1, class_out=1, votes=2.
  - nv=0: expect class_out=0, votes=0, latency 17.
  - nv=15: treated as 10, latency 27.
- Protocol:
  - start pulsed during COUNT: no effect and latency unchanged.
  - Back-to-back start in the cycle after done: accepted.
  - rst pulsed low mid-SCAN: immediate IDLE with all outputs 0. A following start must produce a correct fresh result.
